// File: rtl/serial_rx_package_pkg.sv
// ============================================================================
// serial_rx_package_pkg : shared serial framing constants and receiver states
// Revision 1.0
// ============================================================================
`default_nettype none

package serial_rx_package_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    DATA      = 3'd2,
    STOP      = 3'd3,
    WAIT_IDLE = 3'd4
  } rx_state_e;

  localparam logic c_start_bit = 1'b0;
  localparam logic c_stop_bit  = 1'b1;

endpackage

`default_nettype wire

// File: rtl/serial_rx_package_word.sv
// ============================================================================
// serial_rx_package_word : rx synchroniser, bit timer and byte-framing FSM
// Revision 1.0
// ============================================================================
`default_nettype none

module serial_rx_package_word
  import serial_rx_package_pkg::*;
#(
  parameter int WORD_WIDTH         = 8,
  parameter int SERIAL_TIMER_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_rx,
  output logic [WORD_WIDTH-1:0] o_word,
  output logic                  o_word_valid,
  output logic                  o_frame_error,
  output logic                  o_idle
);

  localparam int BCW = (WORD_WIDTH > 1) ? $clog2(WORD_WIDTH) : 1;
  localparam logic [SERIAL_TIMER_WIDTH-1:0] c_half =
    {1'b1, {(SERIAL_TIMER_WIDTH-1){1'b0}}};
  localparam logic [BCW-1:0] c_last_bit = BCW'(WORD_WIDTH - 1);

  logic                          sync1_q, sync2_q, rx_prev_q;
  rx_state_e                     state_q, state_d;
  logic [SERIAL_TIMER_WIDTH-1:0] timer_q, timer_d;
  logic [BCW-1:0]                bit_cnt_q, bit_cnt_d;
  logic [WORD_WIDTH-1:0]         shift_q, shift_d;

  logic w_rx, w_fall, w_tick, w_mid;
  assign w_rx   = sync2_q;
  assign w_fall = rx_prev_q & ~sync2_q;
  assign w_tick = (timer_q == '1);
  assign w_mid  = (timer_q == c_half);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1_q   <= 1'b1;
      sync2_q   <= 1'b1;
      rx_prev_q <= 1'b1;
      state_q   <= IDLE;
      timer_q   <= '0;
      bit_cnt_q <= '0;
      shift_q   <= '0;
    end else begin
      sync1_q   <= i_rx;
      sync2_q   <= sync1_q;
      rx_prev_q <= sync2_q;
      state_q   <= state_d;
      timer_q   <= timer_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    timer_d   = timer_q + 1'b1;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    case (state_q)
      IDLE: begin
        timer_d   = '0;
        bit_cnt_d = '0;
        if (w_fall) state_d = START;
      end
      START: begin
        // A start bit that is high again at mid-bit is treated as a glitch.
        if (w_mid) begin
          timer_d = '0;
          state_d = (w_rx == c_start_bit) ? DATA : IDLE;
        end
      end
      DATA: begin
        if (w_tick) begin
          shift_d   = {w_rx, shift_q[WORD_WIDTH-1:1]};
          bit_cnt_d = bit_cnt_q + 1'b1;
          if (bit_cnt_q == c_last_bit) begin
            bit_cnt_d = '0;
            state_d   = STOP;
          end
        end
      end
      STOP: begin
        if (w_tick) state_d = (w_rx == c_stop_bit) ? IDLE : WAIT_IDLE;
      end
      WAIT_IDLE: begin
        if (!w_rx)       timer_d = '0;
        else if (w_tick) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    o_word_valid  = 1'b0;
    o_frame_error = 1'b0;
    o_idle        = (state_q == IDLE);
    if (state_q == STOP && w_tick) begin
      if (w_rx == c_stop_bit) o_word_valid  = 1'b1;
      else                    o_frame_error = 1'b1;
    end
  end

  assign o_word = shift_q;

endmodule

`default_nettype wire

// File: rtl/serial_rx_package.sv
// ============================================================================
// serial_rx_package : assembles 2**ADDRESS_WIDTH serial words into one package
// Revision 1.0
// ============================================================================
`default_nettype none

module serial_rx_package
  import serial_rx_package_pkg::*;
#(
  parameter int ADDRESS_WIDTH      = 2,
  parameter int WORD_WIDTH         = 8,
  parameter int SERIAL_TIMER_WIDTH = 8,
  parameter int TIMEOUT_WIDTH      = SERIAL_TIMER_WIDTH + 4
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 rx,
  output logic [(WORD_WIDTH<<ADDRESS_WIDTH)-1:0] Q,
  output logic                                 finish,
  output logic                                 frameError,
  output logic                                 busy
);

  localparam int PKG_WIDTH = WORD_WIDTH << ADDRESS_WIDTH;

  logic [WORD_WIDTH-1:0] w_word;
  logic                  w_word_valid, w_frame_error, w_idle;

  serial_rx_package_word #(
    .WORD_WIDTH        (WORD_WIDTH),
    .SERIAL_TIMER_WIDTH(SERIAL_TIMER_WIDTH)
  ) u_word (
    .clk          (clk),
    .rst          (rst),
    .i_rx         (rx),
    .o_word       (w_word),
    .o_word_valid (w_word_valid),
    .o_frame_error(w_frame_error),
    .o_idle       (w_idle)
  );

  logic [ADDRESS_WIDTH-1:0] idx_q, idx_d;
  logic [PKG_WIDTH-1:0]     shadow_q, shadow_d;
  logic [PKG_WIDTH-1:0]     q_q, q_d;
  logic [TIMEOUT_WIDTH-1:0] idle_cnt_q, idle_cnt_d;
  logic                     finish_q, finish_d;
  logic                     frame_error_q, frame_error_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      idx_q         <= '0;
      shadow_q      <= '0;
      q_q           <= '0;
      idle_cnt_q    <= '0;
      finish_q      <= 1'b0;
      frame_error_q <= 1'b0;
    end else begin
      idx_q         <= idx_d;
      shadow_q      <= shadow_d;
      q_q           <= q_d;
      idle_cnt_q    <= idle_cnt_d;
      finish_q      <= finish_d;
      frame_error_q <= frame_error_d;
    end
  end

  always_comb begin
    idx_d         = idx_q;
    shadow_d      = shadow_q;
    q_d           = q_q;
    idle_cnt_d    = '0;
    finish_d      = 1'b0;
    frame_error_d = w_frame_error;
    if (w_frame_error) begin
      idx_d = '0;
    end else if (w_word_valid) begin
      shadow_d[idx_q*WORD_WIDTH +: WORD_WIDTH] = w_word;
      idx_d = idx_q + 1'b1;
      if (idx_q == '1) begin
        q_d      = shadow_d;
        finish_d = 1'b1;
      end
    end else if (idx_q != '0 && w_idle) begin
      // Partial package silently dropped once the line idles too long.
      if (idle_cnt_q == '1) idx_d = '0;
      else                  idle_cnt_d = idle_cnt_q + 1'b1;
    end
  end

  assign Q          = q_q;
  assign finish     = finish_q;
  assign frameError = frame_error_q;
  assign busy       = (idx_q != '0) || !w_idle;

endmodule

`default_nettype wire
